// File: rtl/onchip_mem_stream_reader_pkg.sv
// onchip_mem_stream_pkg
// Shared types and default sizes for the on-chip memory stream reader.
//   state_t       : controller states (IDLE, RUN, DRAIN, DONE)
//   fifo_entry_t  : default output buffer entry {data, sop, eop}
//   DEF_*         : default parameter values used by the top and the interface
package onchip_mem_stream_pkg;

    localparam int DEF_ADDR_W     = 15;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LEN_W      = 16;
    localparam int DEF_MEM_WORDS  = 32000;
    localparam int DEF_FIFO_DEPTH = 4;

    // The on-chip RAM registers its address and returns q one cycle later
    localparam int MEM_READ_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  sop;
        logic                  eop;
    } fifo_entry_t;

endpackage

// File: rtl/onchip_mem_stream_reader_if.sv
// onchip_mem_stream_reader_if
// Bundles the Avalon-MM read port towards the on-chip RAM (s1) and the
// Avalon-ST output stream of the reader.
//   master modport : the reader (drives mem_* strobes and the stream)
//   slave  modport : the environment (RAM q and stream ready)
interface onchip_mem_stream_reader_if
    import onchip_mem_stream_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [ADDR_W-1:0]   mem_address;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic                mem_clken;
    logic [DATA_W-1:0]   mem_readdata;

    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_sop;
    logic                out_eop;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        input  mem_readdata,
        output out_data, out_valid, out_sop, out_eop,
        input  out_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        output mem_readdata,
        input  out_data, out_valid, out_sop, out_eop,
        output out_ready
    );

endinterface

// File: rtl/onchip_mem_stream_reader_fifo.sv
// onchip_mem_stream_fifo
// Small synchronous FIFO holding stream entries. It has no overflow guard:
// the reader only issues a read when a slot is guaranteed to be free.
//   clk, reset_n : clock and synchronous active-low reset
//   push, push_entry : write one entry
//   pop          : remove the head entry
//   head, empty, count : current head, empty flag and fill level
module onchip_mem_stream_fifo
    import onchip_mem_stream_pkg::*;
#(
    parameter type entry_t = fifo_entry_t,
    parameter int  DEPTH   = DEF_FIFO_DEPTH,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  entry_t           push_entry,
    input  logic             pop,
    output entry_t           head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    entry_t           store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is cleared on reset so the head (and hence out_data) reads 0.
    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (push) begin
                store[wr_ptr] <= push_entry;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = store[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// onchip_mem_stream_reader
// Avalon-MM read master in front of the on-chip RAM. Each command reads
// cmd_len consecutive words starting at cmd_base (wrapping at MEM_WORDS)
// and emits them as one Avalon-ST packet through a credit-managed FIFO.
//   clk, reset_n   : clock, synchronous active-low reset
//   cmd_start/base/len : command (accepted only when idle)
//   busy, done     : status; done is a one-cycle completion pulse
//   bus (master)   : mem_* read port and out_* stream
//   checksum       : sum of popped words of the packet, present only when
//                    ONCHIP_MEM_STREAM_READER_CHECKSUM_EN is defined
module onchip_mem_stream_reader
    import onchip_mem_stream_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int MEM_WORDS  = DEF_MEM_WORDS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              done,
`ifdef ONCHIP_MEM_STREAM_READER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    onchip_mem_stream_reader_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } entry_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  issue_left;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  push_idx;
    logic              inflight;
    logic              issue;
    logic              accept;
    logic              pop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    entry_t            push_entry;
    entry_t            fifo_head;

    assign accept = (state == IDLE) && cmd_start;

    // A read is only issued when its word is guaranteed a FIFO slot, counting
    // the word still in flight from the RAM.
    assign issue = (state == RUN) && (issue_left != '0) &&
                   ((int'(fifo_count) + int'(inflight)) <= (FIFO_DEPTH - MEM_READ_LATENCY));

    assign pop = bus.out_valid && bus.out_ready;

    // Command latching, address walk and read/capture bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            addr       <= '0;
            issue_left <= '0;
            len_q      <= '0;
            push_idx   <= '0;
            inflight   <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (accept) begin
                addr       <= cmd_base;
                issue_left <= cmd_len;
                len_q      <= cmd_len;
                push_idx   <= '0;
            end else begin
                if (issue) begin
                    addr       <= (addr == ADDR_W'(MEM_WORDS - 1)) ? '0 : addr + ADDR_W'(1);
                    issue_left <= issue_left - LEN_W'(1);
                end
                if (inflight) begin
                    push_idx <= push_idx + LEN_W'(1);
                end
            end
        end
    end

    // Next-state logic. DRAIN looks ahead at a pop of the final entry so
    // done follows the last beat by a single cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd_start) begin
                    state_nxt = (cmd_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue && (issue_left == LEN_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight && (fifo_empty || ((fifo_count == CNT_W'(1)) && pop))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // RAM q is valid the cycle after the strobe; sideband travels with it
    assign push_entry.data = bus.mem_readdata;
    assign push_entry.sop  = (push_idx == '0);
    assign push_entry.eop  = (push_idx == (len_q - LEN_W'(1)));

    onchip_mem_stream_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (inflight),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign bus.mem_address    = addr;
    assign bus.mem_chipselect = issue;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = '1;
    assign bus.mem_clken      = 1'b1;

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_head.data;
    assign bus.out_sop   = fifo_head.sop;
    assign bus.out_eop   = fifo_head.eop;

`ifdef ONCHIP_MEM_STREAM_READER_CHECKSUM_EN
    // Running sum of the packet; no pops occur after done, so it holds
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + fifo_head.data;
        end
    end
`endif

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// tb_onchip_mem_stream_reader
// Drives commands against a behavioural RAM and scoreboards the stream
// against the expected word list derived from base, length and RAM contents.
// Build with ONCHIP_MEM_STREAM_READER_CHECKSUM_EN to also check checksum.
module tb_onchip_mem_stream_reader;

    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 32;
    localparam int LEN_W      = 16;
    localparam int MEM_WORDS  = 32000;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_start;
    logic [ADDR_W-1:0] cmd_base;
    logic [LEN_W-1:0]  cmd_len;
    logic              busy;
    logic              done;
`ifdef ONCHIP_MEM_STREAM_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    logic [DATA_W-1:0] ram [MEM_WORDS];
    logic [DATA_W-1:0] ram_q = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ready_mode = 0;
    int ready_phase = 0;

    // Scoreboard state
    bit                mon_en = 1'b0;
    beat_t             exp_q[$];
    beat_t             exp_b;
    beat_t             held;
    bit                stalled;
    int                reads_left;
    logic [ADDR_W-1:0] exp_addr;
    int                outstanding;
    int                beats;
    int                first_valid_cyc;
    int                last_pop_cyc;
    int                done_cyc;
    int                done_count;
    int                start_cyc;
    logic [DATA_W-1:0] sum;

    onchip_mem_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    onchip_mem_stream_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W),
        .MEM_WORDS  (MEM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_start (cmd_start),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .busy      (busy),
        .done      (done),
`ifdef ONCHIP_MEM_STREAM_READER_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Behavioural single-port RAM with one cycle of read latency
    always @(posedge clk) begin
        if (bus.mem_chipselect) ram_q <= ram[bus.mem_address];
    end
    assign bus.mem_readdata = ram_q;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = 1,0,0 repeating, else random
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_phase++;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ((ready_phase % 3) == 0);
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Stream scoreboard, read-address and credit checks
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mem_chipselect) begin
                checkOutput("read_expected", reads_left > 0, 1);
                checkOutput("mem_address", bus.mem_address, exp_addr);
                checkOutput("credit", outstanding < FIFO_DEPTH, 1);
                exp_addr = (int'(exp_addr) == MEM_WORDS - 1) ? '0 : exp_addr + 1'b1;
                reads_left--;
                outstanding++;
            end
            if (bus.out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (stalled) begin
                    checkOutput("hold_data", bus.out_data, held.data);
                    checkOutput("hold_sop", bus.out_sop, held.sop);
                    checkOutput("hold_eop", bus.out_eop, held.eop);
                end
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("extra_beat", bus.out_valid & bus.out_ready, 0);
                    end else begin
                        exp_b = exp_q.pop_front();
                        checkOutput("beat_data", bus.out_data, exp_b.data);
                        checkOutput("beat_sop", bus.out_sop, exp_b.sop);
                        checkOutput("beat_eop", bus.out_eop, exp_b.eop);
                    end
                    sum = sum + bus.out_data;
                    last_pop_cyc = cyc;
                    outstanding--;
                    beats++;
                end
                held    = '{bus.out_data, bus.out_sop, bus.out_eop};
                stalled = !bus.out_ready;
            end else begin
                if (stalled) checkOutput("hold_valid", bus.out_valid, 1);
                stalled = 1'b0;
            end
            if (done) begin
                if (done_cyc < 0) done_cyc = cyc;
                done_count++;
            end
        end
    end

    task automatic checkResetOutputs();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_mem_address", bus.mem_address, 0);
        checkOutput("rst_chipselect", bus.mem_chipselect, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_sop", bus.out_sop, 0);
        checkOutput("rst_out_eop", bus.out_eop, 0);
        checkOutput("rst_out_data", bus.out_data, 0);
    endtask

    // One full command; with poke, cmd_start stays high a second cycle with
    // different arguments, which must be ignored because the block is busy.
    task automatic applyStimulus(input int base, input int len, input int mode, input bit poke);
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{ram[(base + i) % MEM_WORDS], (i == 0), (i == len - 1)});
        end
        reads_left      = len;
        exp_addr        = ADDR_W'(base);
        outstanding     = 0;
        beats           = 0;
        first_valid_cyc = -1;
        last_pop_cyc    = -1;
        done_cyc        = -1;
        done_count      = 0;
        sum             = '0;
        stalled         = 1'b0;
        ready_mode      = mode;
        mon_en          = 1'b1;

        @(posedge clk);
        #1;
        cmd_base  = ADDR_W'(base);
        cmd_len   = LEN_W'(len);
        cmd_start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        checkOutput("busy_after_start", busy, 1);
        if (poke) begin
            cmd_base = ADDR_W'(base + 100);
            cmd_len  = LEN_W'(3);
            @(posedge clk);
            #1;
        end
        cmd_start = 1'b0;

        for (int k = 0; (k < len * 4 + 40) && (done_cyc < 0); k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;

        checkOutput("done_seen", done_cyc >= 0, 1);
        checkOutput("done_width", done_count, 1);
        checkOutput("beat_count", beats, len);
        checkOutput("reads_left", reads_left, 0);
        checkOutput("busy_end", busy, 0);
        if (len == 0) begin
            checkOutput("done_latency_len0", done_cyc - start_cyc, 1);
        end else begin
            checkOutput("done_after_last_pop", done_cyc - last_pop_cyc, 1);
        end
        if ((mode == 0) && (len > 0)) begin
            checkOutput("first_valid_latency", first_valid_cyc - start_cyc, 3);
            checkOutput("throughput", last_pop_cyc - first_valid_cyc, len - 1);
        end
`ifdef ONCHIP_MEM_STREAM_READER_CHECKSUM_EN
        checkOutput("checksum", checksum, sum);
`endif
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) ram[i] = DATA_W'(i);
        reset_n   = 1'b0;
        cmd_start = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs();
        reset_n = 1'b1;

        $display("[TB] basic packet, base 0x10 len 4");
        applyStimulus(16, 4, 0, 0);

        $display("[TB] address wrap, base 31998 len 4");
        applyStimulus(31998, 4, 0, 0);

        $display("[TB] backpressure 1,0,0 pattern, len 8");
        applyStimulus(100, 8, 1, 0);

        $display("[TB] zero length with start held while busy");
        applyStimulus(5, 0, 0, 1);

        $display("[TB] start while busy ignored, len 8");
        applyStimulus(200, 8, 0, 1);

        $display("[TB] reset in the middle of a len 16 transfer");
        mon_en     = 1'b0;
        ready_mode = 1;
        @(posedge clk);
        #1;
        cmd_base  = ADDR_W'(500);
        cmd_len   = LEN_W'(16);
        cmd_start = 1'b1;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkResetOutputs();
        applyStimulus(300, 2, 0, 0);

        $display("[TB] checksum example words");
        ram[0] = 32'hFFFF_FFFF;
        ram[1] = 32'h0000_0002;
        ram[2] = 32'h0000_0003;
        applyStimulus(0, 3, 0, 0);
`ifdef ONCHIP_MEM_STREAM_READER_CHECKSUM_EN
        checkOutput("checksum_example", checksum, 32'h0000_0004);
`endif

        $display("[TB] randomized commands");
        for (int i = 0; i < MEM_WORDS; i++) ram[i] = $urandom;
        for (int r = 0; r < 8; r++) begin
            applyStimulus((r < 3) ? int'($urandom_range(31980, 31999)) : int'($urandom_range(0, MEM_WORDS - 1)),
                          int'($urandom_range(0, 20)), (r == 4) ? 0 : 2, r[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
